// File: rtl/axi_req_arbiter.sv
// Bridges the AXI4-Lite request/response FIFOs to the register file and the TX/RX data FIFOs.
// Writes and reads are round-robin arbitrated; exactly one access is in flight at any time.
module axi_req_arbiter (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        wr_req_empty_i,
    input  logic [1:0]  wr_req_data_i,
    output logic        wr_req_pull_o,
    input  logic        wr_data_empty_i,
    input  logic [35:0] wr_data_data_i,
    output logic        wr_data_pull_o,
    input  logic        wr_resp_full_i,
    output logic [1:0]  wr_resp_data_o,
    output logic        wr_resp_push_o,
    input  logic        rd_req_empty_i,
    input  logic [1:0]  rd_req_data_i,
    output logic        rd_req_pull_o,
    input  logic        rd_resp_full_i,
    output logic [33:0] rd_resp_data_o,
    output logic        rd_resp_push_o,
    input  logic [31:0] reg_control_i,
    input  logic [31:0] reg_trans_ctrl_i,
    input  logic [31:0] reg_status_i,
    input  logic        spi_busy_i,
    output logic [31:0] reg_data_o,
    output logic [1:0]  reg_sel_o,
    output logic        reg_load_o,
    input  logic        tx_full_i,
    output logic [31:0] tx_data_o,
    output logic        tx_push_o,
    input  logic        rx_empty_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_pull_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] SEL_CONTROL = 2'd0;
    localparam logic [1:0] SEL_TRANS   = 2'd1;
    localparam logic [1:0] SEL_STATUS  = 2'd2;
    localparam logic [1:0] SEL_DATA    = 2'd3;

    typedef enum logic [2:0] {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_RESP} state_t;

    state_t      state;
    state_t      next_state;
    logic        last_grant_wr;
    logic [1:0]  rst_sync;
    logic        run;
    logic        wr_ok;
    logic        rd_ok;
    logic        grant_wr;
    logic        grant_rd;
    logic [1:0]  sel;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rd_value;
    logic [31:0] cur_reg;
    logic [31:0] merged;
    logic        wr_load;
    logic        wr_tx;
    logic [1:0]  wr_resp_calc;
    logic [31:0] rd_data_calc;
    logic [1:0]  rd_resp_calc;
    logic        rd_rx;

    // Reset asserts asynchronously but releases only after two clean edges, so no grant
    // (and hence no pull pulse) can appear while reset is active or just released.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run      = rst_sync[1];
    assign wr_ok    = !wr_req_empty_i && !wr_data_empty_i && !wr_resp_full_i;
    assign rd_ok    = !rd_req_empty_i && !rd_resp_full_i;
    assign grant_wr = run && (state == IDLE) && wr_ok && (!rd_ok || !last_grant_wr);
    assign grant_rd = run && (state == IDLE) && rd_ok && (!wr_ok || last_grant_wr);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    next_state = WR_EXEC;
                end else if (grant_rd) begin
                    next_state = RD_EXEC;
                end
            end
            WR_EXEC: next_state = WR_RESP;
            WR_RESP: next_state = IDLE;
            RD_EXEC: next_state = RD_RESP;
            RD_RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Write decode: register writes need an idle SPI engine; DATA writes ignore strobes.
    always_comb begin
        cur_reg      = (sel == SEL_TRANS) ? reg_trans_ctrl_i : reg_control_i;
        merged       = cur_reg;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        wr_load      = 1'b0;
        wr_tx        = 1'b0;
        wr_resp_calc = RESP_SLVERR;
        case (sel)
            SEL_CONTROL, SEL_TRANS: begin
                if (!spi_busy_i) begin
                    wr_resp_calc = RESP_OKAY;
                    wr_load      = |strb;
                end
            end
            SEL_DATA: begin
                if (!tx_full_i) begin
                    wr_tx        = 1'b1;
                    wr_resp_calc = RESP_OKAY;
                end
            end
            default: wr_resp_calc = RESP_SLVERR;
        endcase
    end

    always_comb begin
        rd_data_calc = 32'd0;
        rd_resp_calc = RESP_OKAY;
        rd_rx        = 1'b0;
        case (sel)
            SEL_CONTROL: rd_data_calc = reg_control_i;
            SEL_TRANS:   rd_data_calc = reg_trans_ctrl_i;
            SEL_STATUS:  rd_data_calc = reg_status_i;
            default: begin
                if (!rx_empty_i) begin
                    rd_data_calc = rx_data_i;
                    rd_rx        = 1'b1;
                end else begin
                    rd_resp_calc = RESP_SLVERR;
                end
            end
        endcase
    end

    // Request fields are latched at grant; the result is latched in the execute cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_grant_wr <= 1'b0;
            sel           <= 2'd0;
            wdata         <= 32'd0;
            strb          <= 4'd0;
            resp          <= RESP_OKAY;
            rd_value      <= 32'd0;
        end else begin
            if (grant_wr) begin
                last_grant_wr <= 1'b1;
                sel           <= wr_req_data_i;
                wdata         <= wr_data_data_i[31:0];
                strb          <= wr_data_data_i[35:32];
            end else if (grant_rd) begin
                last_grant_wr <= 1'b0;
                sel           <= rd_req_data_i;
            end
            if (state == WR_EXEC) begin
                resp <= wr_resp_calc;
            end else if (state == RD_EXEC) begin
                resp     <= rd_resp_calc;
                rd_value <= rd_data_calc;
            end
        end
    end

    always_comb begin
        wr_req_pull_o  = 1'b0;
        wr_data_pull_o = 1'b0;
        rd_req_pull_o  = 1'b0;
        wr_resp_push_o = 1'b0;
        wr_resp_data_o = 2'b00;
        rd_resp_push_o = 1'b0;
        rd_resp_data_o = 34'd0;
        reg_load_o     = 1'b0;
        reg_sel_o      = 2'd0;
        reg_data_o     = 32'd0;
        tx_push_o      = 1'b0;
        tx_data_o      = 32'd0;
        rx_pull_o      = 1'b0;
        case (state)
            IDLE: begin
                wr_req_pull_o  = grant_wr;
                wr_data_pull_o = grant_wr;
                rd_req_pull_o  = grant_rd;
            end
            WR_EXEC: begin
                if (wr_load) begin
                    reg_load_o = 1'b1;
                    reg_sel_o  = sel;
                    reg_data_o = merged;
                end
                if (wr_tx) begin
                    tx_push_o = 1'b1;
                    tx_data_o = wdata;
                end
            end
            WR_RESP: begin
                wr_resp_push_o = 1'b1;
                wr_resp_data_o = resp;
            end
            RD_EXEC: rx_pull_o = rd_rx;
            RD_RESP: begin
                rd_resp_push_o = 1'b1;
                rd_resp_data_o = {resp, rd_value};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Bench for axi_req_arbiter: FIFOs are modelled as queues, a cycle-level reference model checks
// every output each cycle, and directed vectors/sequences cover the documented corner cases.
module tb_axi_req_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_req_empty, wr_data_empty, wr_resp_full, rd_req_empty, rd_resp_full;
    logic [1:0]  wr_req_data, rd_req_data;
    logic [35:0] wr_data_data;
    logic [31:0] reg_control, reg_trans_ctrl, reg_status, rx_data;
    logic        spi_busy, tx_full, rx_empty;
    logic        wr_req_pull, wr_data_pull, wr_resp_push, rd_req_pull, rd_resp_push;
    logic [1:0]  wr_resp_data, reg_sel;
    logic [33:0] rd_resp_data;
    logic [31:0] reg_data, tx_data;
    logic        reg_load, tx_push, rx_pull;

    logic [1:0]  wr_req_q[$];
    logic [35:0] wr_data_q[$];
    logic [1:0]  rd_req_q[$];
    logic [31:0] rx_q[$];

    int checks = 0;
    int passes = 0;
    int cycle = 0;

    int          m_phase = 0;
    bit          m_last_wr = 1'b0;
    bit          m_is_wr = 1'b0;
    logic [1:0]  m_sel = 2'd0;
    logic [31:0] m_data = 32'd0;
    logic [3:0]  m_strb = 4'd0;
    logic [1:0]  m_resp = 2'd0;
    logic [31:0] m_rdata = 32'd0;

    int          obs_wr_pull, obs_rd_pull, obs_load, obs_tx, obs_rxpull, obs_bresp_n, obs_rresp_n;
    int          obs_pull_cycle, obs_resp_cycle;
    logic [31:0] obs_load_data, obs_tx_data;
    logic [1:0]  obs_load_sel, obs_bresp;
    logic [33:0] obs_rresp;
    int          grant_cycle_q[$];
    bit          grant_wr_q[$];

    typedef struct {
        bit          is_wr;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          busy;
        bit          txfull;
        bit          rxhas;
        logic [31:0] rxval;
        logic [31:0] ctrl;
        logic [31:0] trans;
        logic [31:0] status;
        int          exp_load;
        logic [31:0] exp_reg_data;
        int          exp_tx;
        int          exp_rxpull;
        logic [1:0]  exp_bresp;
        logic [33:0] exp_rresp;
    } vec_t;

    vec_t vecs[13];

    axi_req_arbiter dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .wr_req_empty_i  (wr_req_empty),
        .wr_req_data_i   (wr_req_data),
        .wr_req_pull_o   (wr_req_pull),
        .wr_data_empty_i (wr_data_empty),
        .wr_data_data_i  (wr_data_data),
        .wr_data_pull_o  (wr_data_pull),
        .wr_resp_full_i  (wr_resp_full),
        .wr_resp_data_o  (wr_resp_data),
        .wr_resp_push_o  (wr_resp_push),
        .rd_req_empty_i  (rd_req_empty),
        .rd_req_data_i   (rd_req_data),
        .rd_req_pull_o   (rd_req_pull),
        .rd_resp_full_i  (rd_resp_full),
        .rd_resp_data_o  (rd_resp_data),
        .rd_resp_push_o  (rd_resp_push),
        .reg_control_i   (reg_control),
        .reg_trans_ctrl_i(reg_trans_ctrl),
        .reg_status_i    (reg_status),
        .spi_busy_i      (spi_busy),
        .reg_data_o      (reg_data),
        .reg_sel_o       (reg_sel),
        .reg_load_o      (reg_load),
        .tx_full_i       (tx_full),
        .tx_data_o       (tx_data),
        .tx_push_o       (tx_push),
        .rx_empty_i      (rx_empty),
        .rx_data_i       (rx_data),
        .rx_pull_o       (rx_pull)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s (cycle %0d): got %h required %h", name, cycle, act, exp);
        end
    endtask

    // Data buses only matter while their strobe is high, so they are masked otherwise.
    function automatic logic [127:0] pack_out(
        input logic wrp, input logic wdp, input logic wrs, input logic [1:0] wrd,
        input logic rrp, input logic rrs, input logic [33:0] rrd,
        input logic [31:0] rgd, input logic [1:0] rgs, input logic rgl,
        input logic [31:0] txd, input logic txp, input logic rxp);
        pack_out = {18'd0, wrp, wdp, wrs, wrs ? wrd : 2'b00, rrp, rrs, rrs ? rrd : 34'd0,
                    rgl ? rgd : 32'd0, rgl ? rgs : 2'd0, rgl, txp ? txd : 32'd0, txp, rxp};
    endfunction

    task automatic refresh_inputs();
        wr_req_empty  = (wr_req_q.size() == 0);
        wr_req_data   = wr_req_empty ? 2'd0 : wr_req_q[0];
        wr_data_empty = (wr_data_q.size() == 0);
        wr_data_data  = wr_data_empty ? 36'd0 : wr_data_q[0];
        rd_req_empty  = (rd_req_q.size() == 0);
        rd_req_data   = rd_req_empty ? 2'd0 : rd_req_q[0];
        rx_empty      = (rx_q.size() == 0);
        rx_data       = rx_empty ? 32'd0 : rx_q[0];
    endtask

    task automatic clear_obs();
        obs_wr_pull = 0; obs_rd_pull = 0; obs_load = 0; obs_tx = 0; obs_rxpull = 0;
        obs_bresp_n = 0; obs_rresp_n = 0; obs_pull_cycle = -100; obs_resp_cycle = -100;
        obs_load_data = 32'd0; obs_tx_data = 32'd0; obs_load_sel = 2'd0;
        obs_bresp = 2'd0; obs_rresp = 34'd0;
        grant_cycle_q.delete();
        grant_wr_q.delete();
    endtask

    // One clock: model predicts outputs from the access rules, DUT is compared mid-cycle,
    // then the queue FIFOs pop whatever the DUT pulled at the edge.
    task automatic run_cycle();
        logic        e_wrp, e_wdp, e_wrs, e_rrp, e_rrs, e_rgl, e_txp, e_rxp;
        logic [1:0]  e_wrd, e_rgs;
        logic [33:0] e_rrd;
        logic [31:0] e_rgd, e_txd, cur;
        logic [35:0] dv;
        bit          wr_ok, rd_ok;
        logic        p_wrq, p_wdq, p_rdq, p_rx;
        @(negedge clk);
        {e_wrp, e_wdp, e_wrs, e_rrp, e_rrs, e_rgl, e_txp, e_rxp} = 8'd0;
        e_wrd = 2'd0; e_rgs = 2'd0; e_rrd = 34'd0; e_rgd = 32'd0; e_txd = 32'd0; cur = 32'd0;
        if (!reset_n) begin
            m_phase = 0;
            m_last_wr = 1'b0;
        end else if (m_phase == 0) begin
            wr_ok = (wr_req_q.size() > 0) && (wr_data_q.size() > 0) && !wr_resp_full;
            rd_ok = (rd_req_q.size() > 0) && !rd_resp_full;
            if (wr_ok && (!rd_ok || !m_last_wr)) begin
                e_wrp = 1'b1; e_wdp = 1'b1;
                dv = wr_data_q[0];
                m_is_wr = 1'b1; m_sel = wr_req_q[0]; m_data = dv[31:0]; m_strb = dv[35:32];
                m_last_wr = 1'b1; m_phase = 1;
            end else if (rd_ok) begin
                e_rrp = 1'b1;
                m_is_wr = 1'b0; m_sel = rd_req_q[0]; m_last_wr = 1'b0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_is_wr) begin
                m_resp = 2'b10;
                if (m_sel < 2'd2) begin
                    if (!spi_busy) begin
                        m_resp = 2'b00;
                        if (m_strb != 4'd0) begin
                            cur = (m_sel == 2'd0) ? reg_control : reg_trans_ctrl;
                            for (int b = 0; b < 4; b++) begin
                                e_rgd[8*b +: 8] = m_strb[b] ? m_data[8*b +: 8] : cur[8*b +: 8];
                            end
                            e_rgl = 1'b1; e_rgs = m_sel;
                        end
                    end
                end else if (m_sel == 2'd3 && !tx_full) begin
                    e_txp = 1'b1; e_txd = m_data; m_resp = 2'b00;
                end
            end else begin
                m_resp = 2'b00;
                if (m_sel == 2'd0) m_rdata = reg_control;
                else if (m_sel == 2'd1) m_rdata = reg_trans_ctrl;
                else if (m_sel == 2'd2) m_rdata = reg_status;
                else if (rx_q.size() > 0) begin
                    m_rdata = rx_q[0]; e_rxp = 1'b1;
                end else begin
                    m_rdata = 32'd0; m_resp = 2'b10;
                end
            end
            m_phase = 2;
        end else begin
            if (m_is_wr) begin
                e_wrs = 1'b1; e_wrd = m_resp;
            end else begin
                e_rrs = 1'b1; e_rrd = {m_resp, m_rdata};
            end
            m_phase = 0;
        end
        checkOutput("cycle_outputs",
            pack_out(wr_req_pull, wr_data_pull, wr_resp_push, wr_resp_data, rd_req_pull, rd_resp_push,
                     rd_resp_data, reg_data, reg_sel, reg_load, tx_data, tx_push, rx_pull),
            pack_out(e_wrp, e_wdp, e_wrs, e_wrd, e_rrp, e_rrs, e_rrd, e_rgd, e_rgs, e_rgl, e_txd, e_txp, e_rxp));
        if (wr_req_pull) begin obs_wr_pull++; obs_pull_cycle = cycle; grant_cycle_q.push_back(cycle); grant_wr_q.push_back(1'b1); end
        if (rd_req_pull) begin obs_rd_pull++; obs_pull_cycle = cycle; grant_cycle_q.push_back(cycle); grant_wr_q.push_back(1'b0); end
        if (reg_load) begin obs_load++; obs_load_data = reg_data; obs_load_sel = reg_sel; end
        if (tx_push) begin obs_tx++; obs_tx_data = tx_data; end
        if (rx_pull) obs_rxpull++;
        if (wr_resp_push) begin obs_bresp_n++; obs_bresp = wr_resp_data; obs_resp_cycle = cycle; end
        if (rd_resp_push) begin obs_rresp_n++; obs_rresp = rd_resp_data; obs_resp_cycle = cycle; end
        p_wrq = wr_req_pull; p_wdq = wr_data_pull; p_rdq = rd_req_pull; p_rx = rx_pull;
        @(posedge clk);
        #1;
        if (p_wrq && wr_req_q.size() > 0) void'(wr_req_q.pop_front());
        if (p_wdq && wr_data_q.size() > 0) void'(wr_data_q.pop_front());
        if (p_rdq && rd_req_q.size() > 0) void'(rd_req_q.pop_front());
        if (p_rx && rx_q.size() > 0) void'(rx_q.pop_front());
        refresh_inputs();
        cycle++;
    endtask

    task automatic clear_fifos();
        wr_req_q.delete(); wr_data_q.delete(); rd_req_q.delete(); rx_q.delete();
        wr_resp_full = 1'b0; rd_resp_full = 1'b0; spi_busy = 1'b0; tx_full = 1'b0;
        refresh_inputs();
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        clear_fifos();
        repeat (2) run_cycle();
        reset_n = 1'b1;
        repeat (3) run_cycle();
    endtask

    task automatic applyStimulus(input vec_t v);
        reg_control = v.ctrl; reg_trans_ctrl = v.trans; reg_status = v.status;
        spi_busy = v.busy; tx_full = v.txfull;
        if (v.rxhas) rx_q.push_back(v.rxval);
        if (v.is_wr) begin
            wr_req_q.push_back(v.sel);
            wr_data_q.push_back({v.strb, v.data});
        end else begin
            rd_req_q.push_back(v.sel);
        end
        refresh_inputs();
        clear_obs();
    endtask

    initial begin
        logic [31:0] c_val, t_val, s_val;
        c_val = 32'h1122_3344; t_val = 32'hCAFE_F00D; s_val = 32'h0000_0081;
        vecs[0]  = '{1'b1, 2'd0, 32'h0000_00A5, 4'hF, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 1, 32'h0000_00A5, 0, 0, 2'b00, 34'd0};
        vecs[1]  = '{1'b1, 2'd0, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 1, 32'h11BB_33DD, 0, 0, 2'b00, 34'd0};
        vecs[2]  = '{1'b1, 2'd1, 32'h1234_5678, 4'hC, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 1, 32'h1234_F00D, 0, 0, 2'b00, 34'd0};
        vecs[3]  = '{1'b1, 2'd1, 32'h0BAD_0BAD, 4'hF, 1'b1, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b10, 34'd0};
        vecs[4]  = '{1'b1, 2'd2, 32'h0000_FFFF, 4'hF, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b10, 34'd0};
        vecs[5]  = '{1'b1, 2'd3, 32'h55AA_55AA, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 1, 0, 2'b00, 34'd0};
        vecs[6]  = '{1'b1, 2'd3, 32'h0123_4567, 4'hF, 1'b0, 1'b1, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b10, 34'd0};
        vecs[7]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b00, 34'd0};
        vecs[8]  = '{1'b0, 2'd0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b00, 34'h0_1122_3344};
        vecs[9]  = '{1'b0, 2'd1, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b00, 34'h0_CAFE_F00D};
        vecs[10] = '{1'b0, 2'd2, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b00, 34'h0_0000_0081};
        vecs[11] = '{1'b0, 2'd3, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, 32'd0, c_val, t_val, s_val, 0, 32'd0, 0, 0, 2'b00, 34'h2_0000_0000};
        vecs[12] = '{1'b0, 2'd3, 32'd0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, c_val, t_val, s_val, 0, 32'd0, 0, 1, 2'b00, 34'h0_DEAD_BEEF};

        reg_control = 32'd0; reg_trans_ctrl = 32'd0; reg_status = 32'd0;
        clear_fifos();
        clear_obs();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_outputs", {18'd0, wr_req_pull, wr_data_pull, wr_resp_push, wr_resp_data, rd_req_pull,
                    rd_resp_push, rd_resp_data, reg_data, reg_sel, reg_load, tx_data, tx_push, rx_pull}, 128'd0);
        reset_dut();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            repeat (5) run_cycle();
            if (vecs[i].is_wr) begin
                checkOutput("wr_resp_count", 128'(obs_bresp_n), 128'(1));
                checkOutput("wr_resp_value", 128'(obs_bresp), 128'(vecs[i].exp_bresp));
            end else begin
                checkOutput("rd_resp_count", 128'(obs_rresp_n), 128'(1));
                checkOutput("rd_resp_value", 128'(obs_rresp), 128'(vecs[i].exp_rresp));
            end
            checkOutput("resp_latency", 128'(obs_resp_cycle - obs_pull_cycle), 128'(2));
            checkOutput("reg_load_count", 128'(obs_load), 128'(vecs[i].exp_load));
            if (vecs[i].exp_load != 0) begin
                checkOutput("reg_data", 128'(obs_load_data), 128'(vecs[i].exp_reg_data));
                checkOutput("reg_sel", 128'(obs_load_sel), 128'(vecs[i].sel));
            end
            checkOutput("tx_push_count", 128'(obs_tx), 128'(vecs[i].exp_tx));
            if (vecs[i].exp_tx != 0) checkOutput("tx_data", 128'(obs_tx_data), 128'(vecs[i].data));
            checkOutput("rx_pull_count", 128'(obs_rxpull), 128'(vecs[i].exp_rxpull));
            clear_fifos();
        end

        // Writes and reads both pending from reset: write first, then strict alternation.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            wr_req_q.push_back(2'd0);
            wr_data_q.push_back({4'hF, 32'h1000_0000 + 32'(i)});
            rd_req_q.push_back(2'd2);
        end
        refresh_inputs();
        clear_obs();
        repeat (20) run_cycle();
        checkOutput("grant_count", 128'(grant_wr_q.size()), 128'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < grant_wr_q.size()) begin
                checkOutput("grant_order", 128'(grant_wr_q[i]), 128'(i % 2 == 0));
                if (i > 0) checkOutput("grant_spacing", 128'(grant_cycle_q[i] - grant_cycle_q[i-1]), 128'(3));
            end
        end

        // A full read response FIFO holds the read off until it drains.
        rd_resp_full = 1'b1;
        rd_req_q.push_back(2'd1);
        refresh_inputs();
        clear_obs();
        repeat (6) run_cycle();
        checkOutput("rd_pull_while_full", 128'(obs_rd_pull), 128'(0));
        rd_resp_full = 1'b0;
        repeat (4) run_cycle();
        checkOutput("rd_pull_after_drain", 128'(obs_rd_pull), 128'(1));
        checkOutput("rd_resp_after_drain", 128'(obs_rresp_n), 128'(1));

        // Reset landing in WR_EXEC drops the access without a response.
        clear_fifos();
        clear_obs();
        wr_req_q.push_back(2'd0);
        wr_data_q.push_back({4'hF, 32'h0000_0077});
        refresh_inputs();
        run_cycle();
        checkOutput("midreset_grant", 128'(obs_wr_pull), 128'(1));
        reset_n = 1'b0;
        clear_fifos();
        #1;
        checkOutput("midreset_outputs", {18'd0, wr_req_pull, wr_data_pull, wr_resp_push, wr_resp_data, rd_req_pull,
                    rd_resp_push, rd_resp_data, reg_data, reg_sel, reg_load, tx_data, tx_push, rx_pull}, 128'd0);
        clear_obs();
        repeat (2) run_cycle();
        reset_n = 1'b1;
        repeat (5) run_cycle();
        checkOutput("midreset_no_resp", 128'(obs_bresp_n), 128'(0));
        checkOutput("midreset_no_load", 128'(obs_load), 128'(0));

        // Randomised traffic against the cycle model.
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 20 && wr_req_q.size() < 4) wr_req_q.push_back(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) < 20 && wr_data_q.size() < 4)
                wr_data_q.push_back({4'($urandom_range(1, 15)), 32'($urandom)});
            if ($urandom_range(0, 99) < 20 && rd_req_q.size() < 4) rd_req_q.push_back(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) < 15 && rx_q.size() < 4) rx_q.push_back(32'($urandom));
            wr_resp_full = ($urandom_range(0, 9) == 0);
            rd_resp_full = ($urandom_range(0, 9) == 0);
            spi_busy     = ($urandom_range(0, 3) == 0);
            tx_full      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) reg_control    = 32'($urandom);
            if ($urandom_range(0, 9) == 0) reg_trans_ctrl = 32'($urandom);
            if ($urandom_range(0, 9) == 0) reg_status     = 32'($urandom);
            refresh_inputs();
            run_cycle();
        end
        wr_resp_full = 1'b0;
        rd_resp_full = 1'b0;
        repeat (30) run_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
